mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sits directly upstream of the byte-addressable 32-bit memory. Arbitrates
//  the instruction-fetch port and the load/store port onto that memory's
//  single port. Serves one access every three cycles. Flags misaligned
//  accesses and sign/zero-extends byte and halfword loads.
// PARAMETERS
//  ADDR_WIDTH   16   width of all address buses
// PORTS
//  i_clk        in   1   clock; all state changes on rising edge
//  i_reset_n    in   1   asynchronous, active-low reset
//  i_if_req     in   1   fetch request; held high until o_if_ack
//  i_if_addr    in   AW  fetch address; always a word access
//  o_if_ack     out  1   one-cycle pulse; o_if_data valid this cycle
//  o_if_data    out  32  fetched word
//  i_ls_req     in   1   load/store request; held high until o_ls_ack
//  i_ls_wr      in   1   1 = store, 0 = load
//  i_ls_size    in   2   00 byte, 01/10 halfword, 11 word
//  i_ls_signed  in   1   sign-extend byte/halfword loads
//  i_ls_addr    in   AW  load/store address
//  i_ls_data    in   32  store data, right-justified
//  o_ls_ack     out  1   one-cycle completion pulse
//  o_ls_data    out  32  extended load data; 0 for stores and errors
//  o_ls_err     out  1   valid with o_ls_ack; 1 = misaligned, no access made
//  o_mem_addr   out  AW  memory address
//  o_mem_data   out  32  memory write data
//  o_mem_size   out  2   memory access size
//  o_mem_we     out  1   memory write enable, active low
//  i_mem_data   in   32  memory read data (combinational from o_mem_addr/size)
// BEHAVIOUR
//  Reset values: state IDLE, last=LS, all acks 0, o_*_data 0, o_ls_err 0.
//  Idle memory bus (outside IF_ACC/LS_ACC): addr 0, data 0, size 11, we 1.
//  Reset is asynchronous, so o_mem_we returns to 1 the moment i_reset_n
//  falls. An in-flight store whose edge has not yet occurred is therefore
//  dropped, and no ack is issued.
//  FSM states: IDLE, IF_ACC, LS_ACC, RESP.
//   IDLE: requests are sampled here.
//    - Only if_req: go to IF_ACC.
//    - Only ls_req: go to LS_ACC.
//    - Both: grant the requester that is not 'last'. After reset, fetch
//      wins the first tie.
//    - Misaligned ls request goes straight to RESP with err=1. It makes no
//      memory access and does not update 'last'. Misaligned means halfword
//      with addr[0]=1, or word with addr[1:0]!=00.
//   IF_ACC: drive addr=i_if_addr, size=11, we=1.
//    - Capture i_mem_data into o_if_data at the edge.
//    - Set last=IF; go to RESP.
//   LS_ACC: drive addr/size from the ls port.
//    - Store: we=0 for exactly this cycle, o_mem_data=i_ls_data.
//    - Load: capture extended data into o_ls_data; stores capture 0.
//    - Set last=LS; go to RESP.
//   RESP: pulse the granted port's ack for one cycle, then go to IDLE.
//    - No new grant is made in RESP; the requester drops or re-raises req.
//  Latency: req seen in IDLE at cycle N -> ack in cycle N+2.
//   Misaligned: ack in cycle N+1.
//  Load extension: byte uses i_mem_data[7:0], halfword uses [15:0].
//   signed -> replicate the top bit; unsigned -> zero-fill. Word passes
//   through. i_ls_signed is ignored for words and stores.
//  Data registers hold their value after ack until the next capture.
// TESTING
//  1. Reset mid-run -> all acks 0, o_mem_we 1, o_mem_size 11, state IDLE.
//  2. Fetch 0x0010, word there 0xDEADBEEF -> o_if_ack at N+2,
//     o_if_data=0xDEADBEEF, o_mem_size 11 in cycle N+1.
//  3. Byte load 0x0013 holding 0x80: signed -> 0xFFFFFF80,
//     unsigned -> 0x00000080. Halfword 0x0012 holding 0x8001, signed
//     -> 0xFFFF8001.
//  4. if_req and ls_req held continuously from reset -> grants IF, LS, IF,
//     LS. Each ack is 3 cycles apart and the other port sees no ack.
//  5. Word store 0x0002 -> o_ls_ack at N+1 with err=1, data 0, o_mem_we
//     never 0. Word at 0x0000 unchanged on read-back.
//  6. Store 0x11223344 to 0x0020; i_reset_n falls in LS_ACC before the
//     edge -> o_mem_we=1 at once, no ack, read-back shows old contents.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port byte-addressable 32-bit memory.
// One access per three cycles; rejects misaligned load/store and extends narrow loads.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_if_req,
   input  logic [ADDR_WIDTH-1:0] i_if_addr,
   output logic                  o_if_ack,
   output logic [31:0]           o_if_data,
   input  logic                  i_ls_req,
   input  logic                  i_ls_wr,
   input  logic [1:0]            i_ls_size,
   input  logic                  i_ls_signed,
   input  logic [ADDR_WIDTH-1:0] i_ls_addr,
   input  logic [31:0]           i_ls_data,
   output logic                  o_ls_ack,
   output logic [31:0]           o_ls_data,
   output logic                  o_ls_err,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [31:0]           o_mem_data,
   output logic [1:0]            o_mem_size,
   output logic                  o_mem_we,
   input  logic [31:0]           i_mem_data
);

   typedef enum logic [1:0] {IDLE, IF_ACC, LS_ACC, RESP} state_t;

   state_t      state_q;
   logic        last_ls_q;
   logic        if_ack_q;
   logic        ls_ack_q;
   logic        ls_err_q;
   logic [31:0] if_data_q;
   logic [31:0] ls_data_q;

   logic        ls_misaligned;
   logic        grant_ls;
   logic [31:0] ld_ext;

   always_comb begin
      case (i_ls_size)
         2'b00:   ls_misaligned = 1'b0;
         2'b11:   ls_misaligned = |i_ls_addr[1:0];
         default: ls_misaligned = i_ls_addr[0];
      endcase
   end

   // Ties go to whichever port was not served last.
   assign grant_ls = i_ls_req && (!i_if_req || !last_ls_q);

   always_comb begin
      case (i_ls_size)
         2'b00:        ld_ext = {{24{i_ls_signed & i_mem_data[7]}}, i_mem_data[7:0]};
         2'b01, 2'b10: ld_ext = {{16{i_ls_signed & i_mem_data[15]}}, i_mem_data[15:0]};
         default:      ld_ext = i_mem_data;
      endcase
   end

   // Bus decoded straight from state so an async reset releases write enable immediately.
   always_comb begin
      o_mem_addr = '0;
      o_mem_data = '0;
      o_mem_size = 2'b11;
      o_mem_we   = 1'b1;
      case (state_q)
         IF_ACC: o_mem_addr = i_if_addr;
         LS_ACC: begin
            o_mem_addr = i_ls_addr;
            o_mem_size = i_ls_size;
            if (i_ls_wr) begin
               o_mem_we   = 1'b0;
               o_mem_data = i_ls_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= IDLE;
         last_ls_q <= 1'b1;
         if_ack_q  <= 1'b0;
         ls_ack_q  <= 1'b0;
         ls_err_q  <= 1'b0;
         if_data_q <= '0;
         ls_data_q <= '0;
      end else begin
         if_ack_q <= 1'b0;
         ls_ack_q <= 1'b0;
         ls_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_ls) begin
                  if (ls_misaligned) begin
                     state_q   <= RESP;
                     ls_ack_q  <= 1'b1;
                     ls_err_q  <= 1'b1;
                     ls_data_q <= '0;
                  end else begin
                     state_q <= LS_ACC;
                  end
               end else if (i_if_req) begin
                  state_q <= IF_ACC;
               end
            end
            IF_ACC: begin
               if_data_q <= i_mem_data;
               if_ack_q  <= 1'b1;
               last_ls_q <= 1'b0;
               state_q   <= RESP;
            end
            LS_ACC: begin
               ls_data_q <= i_ls_wr ? 32'h0 : ld_ext;
               ls_ack_q  <= 1'b1;
               last_ls_q <= 1'b1;
               state_q   <= RESP;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_if_ack  = if_ack_q;
   assign o_if_data = if_data_q;
   assign o_ls_ack  = ls_ack_q;
   assign o_ls_data = ls_data_q;
   assign o_ls_err  = ls_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: little-endian byte memory model plus a scoreboard of
// expected acks (port, data, err, cycle) popped as the DUT acknowledges.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req, ls_req, ls_wr, ls_signed;
   logic [AW-1:0] if_addr, ls_addr;
   logic [1:0]    ls_size;
   logic [31:0]   ls_data;
   logic          if_ack, ls_ack, ls_err, mem_we;
   logic [31:0]   if_data, ls_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic [1:0]    mem_size;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_WIDTH(AW)) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_data(if_data),
      .i_ls_req(ls_req), .i_ls_wr(ls_wr), .i_ls_size(ls_size), .i_ls_signed(ls_signed),
      .i_ls_addr(ls_addr), .i_ls_data(ls_data), .o_ls_ack(ls_ack), .o_ls_data(ls_rdata),
      .o_ls_err(ls_err), .o_mem_addr(mem_addr), .o_mem_data(mem_wdata),
      .o_mem_size(mem_size), .o_mem_we(mem_we), .i_mem_data(mem_rdata)
   );

   // Memory model
   logic [7:0] mem [0:255];
   logic [7:0] a0, a1, a2, a3;
   logic       poke_en = 1'b0;
   logic [7:0] poke_a, poke_b;

   always_comb begin
      a0 = mem_addr[7:0];
      a1 = a0 + 8'd1;
      a2 = a0 + 8'd2;
      a3 = a0 + 8'd3;
      mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
   end

   always @(posedge clk) begin
      if (poke_en) begin
         mem[poke_a] <= poke_b;
      end else if (!mem_we) begin
         mem[a0] <= mem_wdata[7:0];
         if (mem_size != 2'b00) mem[a1] <= mem_wdata[15:8];
         if (mem_size == 2'b11) begin
            mem[a2] <= mem_wdata[23:16];
            mem[a3] <= mem_wdata[31:24];
         end
      end
   end

   // Scoreboard
   typedef struct packed {
      logic        port;   // 0 = fetch, 1 = load/store
      logic        err;
      logic [31:0] data;
      logic [31:0] cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] cyc      = '0;
   logic        watch_we = 1'b0;
   int          we_low_cnt = 0;

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (watch_we && !mem_we) we_low_cnt++;
      if (rst_n && (if_ack || ls_ack)) begin
         check("single_ack", {31'b0, if_ack & ls_ack}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("ack_port", {31'b0, ls_ack}, {31'b0, e.port});
            check("ack_cycle", cyc, e.cyc);
            check("ack_data", e.port ? ls_rdata : if_data, e.data);
            check("ack_err", {31'b0, ls_err}, {31'b0, e.port & e.err});
            $display("txn cyc=%0d port=%s data=%h err=%b", cyc, ls_ack ? "LS" : "IF",
                     ls_ack ? ls_rdata : if_data, ls_err);
         end
      end
   end

   task automatic poke_word(input logic [7:0] a, input logic [31:0] w);
      logic [31:0] v;
      v = w;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         poke_en = 1'b1;
         poke_a  = a + 8'(k);
         poke_b  = v[7:0];
         v       = v >> 8;
      end
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   task automatic wait_ack(input logic port);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if ((port ? ls_ack : if_ack) === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check(port ? "ls_ack_seen" : "if_ack_seen", {31'b0, got}, 32'd1);
   endtask

   task automatic run_if(input logic [AW-1:0] a, input logic [31:0] exp_d);
      @(posedge clk); #1;
      if_req  = 1'b1;
      if_addr = a;
      sb.push_back('{port: 1'b0, err: 1'b0, data: exp_d, cyc: cyc + 32'd2});
      @(negedge clk);
      @(negedge clk);
      check("if_mem_size", {30'b0, mem_size}, 32'd3);
      check("if_mem_addr", {16'b0, mem_addr}, {16'b0, a});
      check("if_mem_we", {31'b0, mem_we}, 32'd1);
      wait_ack(1'b0);
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   task automatic run_ls(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic exp_e);
      @(posedge clk); #1;
      ls_req = 1'b1; ls_wr = wr; ls_size = sz; ls_signed = sgn; ls_addr = a; ls_data = d;
      sb.push_back('{port: 1'b1, err: exp_e, data: exp_d, cyc: cyc + (exp_e ? 32'd1 : 32'd2)});
      @(negedge clk);
      @(negedge clk);
      if (!exp_e && wr) begin
         check("st_mem_we", {31'b0, mem_we}, 32'd0);
         check("st_mem_data", mem_wdata, d);
      end
      wait_ack(1'b1);
      @(posedge clk); #1;
      ls_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      if_req = 1'b1; if_addr = 16'h0010;
      ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b11; ls_signed = 1'b0;
      ls_addr = 16'h0020; ls_data = '0;

      poke_word(8'h00, 32'h55AA33CC);
      poke_word(8'h10, 32'hDEADBEEF);
      poke_word(8'h20, 32'hCAFEF00D);

      @(negedge clk);
      check("rst_if_ack", {31'b0, if_ack}, 32'd0);
      check("rst_ls_ack", {31'b0, ls_ack}, 32'd0);
      check("rst_if_data", if_data, 32'd0);
      check("rst_ls_data", ls_rdata, 32'd0);
      check("rst_ls_err", {31'b0, ls_err}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd1);
      check("rst_mem_size", {30'b0, mem_size}, 32'd3);
      check("rst_mem_addr", {16'b0, mem_addr}, 32'd0);

      // Both ports requesting from reset: IF, LS, IF, LS, three cycles apart
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.push_back('{port: 1'b0, err: 1'b0, data: 32'hDEADBEEF, cyc: cyc + 32'd2});
      sb.push_back('{port: 1'b1, err: 1'b0, data: 32'hCAFEF00D, cyc: cyc + 32'd5});
      sb.push_back('{port: 1'b0, err: 1'b0, data: 32'hDEADBEEF, cyc: cyc + 32'd8});
      sb.push_back('{port: 1'b1, err: 1'b0, data: 32'hCAFEF00D, cyc: cyc + 32'd11});
      repeat (12) @(posedge clk);
      #1;
      if_req = 1'b0;
      ls_req = 1'b0;
      check("sb_empty_tie", 32'(sb.size()), 32'd0);

      run_if(16'h0010, 32'hDEADBEEF);

      // Narrow stores then extended loads
      run_ls(1'b1, 2'b01, 1'b0, 16'h0012, 32'hFFFF8001, 32'h0, 1'b0);
      run_ls(1'b1, 2'b00, 1'b0, 16'h0021, 32'h12345677, 32'h0, 1'b0);
      run_ls(1'b1, 2'b10, 1'b0, 16'h0022, 32'h0000BEEF, 32'h0, 1'b0);
      run_ls(1'b0, 2'b00, 1'b1, 16'h0013, 32'h0, 32'hFFFFFF80, 1'b0);
      run_ls(1'b0, 2'b00, 1'b0, 16'h0013, 32'h0, 32'h00000080, 1'b0);
      run_ls(1'b0, 2'b01, 1'b1, 16'h0012, 32'h0, 32'hFFFF8001, 1'b0);
      run_ls(1'b0, 2'b10, 1'b0, 16'h0012, 32'h0, 32'h00008001, 1'b0);
      run_ls(1'b0, 2'b00, 1'b1, 16'h0011, 32'h0, 32'hFFFFFFBE, 1'b0);
      run_ls(1'b0, 2'b01, 1'b1, 16'h0010, 32'h0, 32'hFFFFBEEF, 1'b0);
      run_ls(1'b0, 2'b11, 1'b1, 16'h0010, 32'h0, 32'h8001BEEF, 1'b0);
      run_ls(1'b0, 2'b11, 1'b0, 16'h0020, 32'h0, 32'hBEEF770D, 1'b0);

      // Misaligned requests: immediate error ack, no memory write
      watch_we = 1'b1;
      run_ls(1'b1, 2'b11, 1'b0, 16'h0002, 32'hFFFFFFFF, 32'h0, 1'b1);
      run_ls(1'b0, 2'b01, 1'b1, 16'h0013, 32'h0, 32'h0, 1'b1);
      run_ls(1'b1, 2'b10, 1'b0, 16'h0001, 32'hFFFFFFFF, 32'h0, 1'b1);
      run_ls(1'b0, 2'b11, 1'b0, 16'h0001, 32'h0, 32'h0, 1'b1);
      watch_we = 1'b0;
      check("mis_we_never_low", 32'(we_low_cnt), 32'd0);
      run_ls(1'b0, 2'b11, 1'b0, 16'h0000, 32'h0, 32'h55AA33CC, 1'b0);

      // Fetch leaves last=IF; then a store is cut off by reset mid-access
      run_if(16'h0010, 32'h8001BEEF);
      @(posedge clk); #1;
      ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b11; ls_addr = 16'h0020; ls_data = 32'h11223344;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_mem_we", {31'b0, mem_we}, 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_mem_we", {31'b0, mem_we}, 32'd1);
      check("mid_rst_mem_size", {30'b0, mem_size}, 32'd3);
      check("mid_rst_mem_addr", {16'b0, mem_addr}, 32'd0);
      check("mid_rst_ls_ack", {31'b0, ls_ack}, 32'd0);
      check("mid_rst_if_ack", {31'b0, if_ack}, 32'd0);
      check("mid_rst_if_data", if_data, 32'd0);
      check("mid_rst_ls_data", ls_rdata, 32'd0);
      @(posedge clk); #1;
      ls_req = 1'b0; ls_wr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Tie after reset goes to fetch again; load reads back the unwritten word
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 16'h0010;
      ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b11; ls_signed = 1'b0; ls_addr = 16'h0020;
      sb.push_back('{port: 1'b0, err: 1'b0, data: 32'h8001BEEF, cyc: cyc + 32'd2});
      sb.push_back('{port: 1'b1, err: 1'b0, data: 32'hBEEF770D, cyc: cyc + 32'd5});
      repeat (6) @(posedge clk);
      #1;
      if_req = 1'b0;
      ls_req = 1'b0;
      repeat (4) @(negedge clk);
      check("sb_empty_end", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
